// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the four-way memory port arbiter and its users.
// Requester indices match the 4:1 address/write-data mux select encoding.
package mem_port_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] REQ_IF  = 2'd0;
    localparam logic [SEL_W-1:0] REQ_LS  = 2'd1;
    localparam logic [SEL_W-1:0] REQ_DMA = 2'd2;
    localparam logic [SEL_W-1:0] REQ_DBG = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Raw encodings for the FSM register; kept equal to arb_state_e.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin search: first unmasked request after 'last',
// wrapping from the top index back to zero.
module rr_picker
    import mem_port_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic [NREQ-1:0] eligible;

    assign eligible = req & ~mask;

    // Walk offsets from farthest to nearest so the nearest hit is kept.
    always_comb begin
        logic [SEL_W-1:0] cand;
        any  = 1'b0;
        win  = '0;
        cand = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = last + SEL_W'(i);
            if (eligible[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared 32-bit memory port: holds the grant for a
// whole transaction, hands off without a bubble, and aborts on a stalled port.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no owner; grant/mem_valid low, sel holds the previous owner
//   ST_BUSY | owner in grant/sel, mem_valid high, watchdog counting stalls
module mem_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic                      mem_ready,
    output logic [$clog2(NREQ)-1:0]   sel,
    output logic [NREQ-1:0]           grant,
    output logic                      mem_valid,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           err,
    output logic [CNT_W-1:0]          busy_cnt
);
    import mem_port_arbiter_pkg::*;

    localparam bit               WD_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    logic [0:0]       state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] last_q;
    logic [NREQ-1:0]  grant_q;
    logic             valid_q;
    logic [NREQ-1:0]  done_q;
    logic [NREQ-1:0]  err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NREQ-1:0]  pick_mask;
    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic             timeout_hit;
    logic             xfer_end;

    // The current owner never wins the re-arbitration at its own end.
    assign pick_mask   = (state_q == ST_BUSY) ? grant_q : '0;
    assign timeout_hit = WD_EN && (cnt_q == TO_LAST) && !mem_ready;
    assign xfer_end    = mem_ready || timeout_hit;

    rr_picker u_picker (
        .req  (req),
        .mask (pick_mask),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= REQ_DBG;
            grant_q <= '0;
            valid_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q <= ST_BUSY;
                        grant_q <= idx_to_onehot(pick_win);
                        sel_q   <= pick_win;
                        last_q  <= pick_win;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (xfer_end) begin
                        // Completion takes precedence over a coincident timeout.
                        if (mem_ready) begin
                            done_q <= grant_q;
                        end else begin
                            err_q <= grant_q;
                        end
                        cnt_q <= '0;
                        if (pick_any) begin
                            grant_q <= idx_to_onehot(pick_win);
                            sel_q   <= pick_win;
                            last_q  <= pick_win;
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            valid_q <= 1'b0;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign mem_valid = valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model (owner index, wait count, round-robin search by modular arithmetic).
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic             mem_ready;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic             mem_valid;
    logic [3:0]       done;
    logic [3:0]       err;
    logic [CNT_W-1:0] busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: owner index (-1 = none), last served, stall count, pulses.
    int m_owner = -1;
    int m_last  = 3;
    int m_wait  = 0;
    int m_sel   = 0;
    int m_done  = -1;
    int m_err   = -1;

    mem_port_arbiter #(.NREQ(4), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mem_ready (mem_ready),
        .sel       (sel),
        .grant     (grant),
        .mem_valid (mem_valid),
        .done      (done),
        .err       (err),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [3:0] r, input int excl, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_wait  = 0;
        m_sel   = 0;
        m_done  = -1;
        m_err   = -1;
    endtask

    task automatic model_step();
        int w;
        bit ended;
        m_done = -1;
        m_err  = -1;
        ended  = 1'b0;
        if (m_owner < 0) begin
            w = rr_pick(req, -1, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_sel   = w;
                m_wait  = 0;
            end
        end else begin
            if (mem_ready) begin
                m_done = m_owner;
                ended  = 1'b1;
            end else if (TIMEOUT > 0 && m_wait == TIMEOUT - 1) begin
                m_err = m_owner;
                ended = 1'b1;
            end else if (m_wait < (1 << CNT_W) - 1) begin
                m_wait++;
            end
            if (ended) begin
                w      = rr_pick(req, m_owner, m_last);
                m_wait = 0;
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                    m_sel   = w;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grant"},    32'(grant),     (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
        chk({tag, ".sel"},      32'(sel),       32'(m_sel));
        chk({tag, ".valid"},    32'(mem_valid), (m_owner < 0) ? 32'd0 : 32'd1);
        chk({tag, ".done"},     32'(done),      (m_done < 0) ? 32'd0 : 32'(1 << m_done));
        chk({tag, ".err"},      32'(err),       (m_err < 0) ? 32'd0 : 32'(1 << m_err));
        chk({tag, ".busy_cnt"}, 32'(busy_cnt),  32'(m_wait));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        mem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, then completion back to idle.
        req = 4'b0001;
        step("single_grant");
        chk("single_grant_lit", 32'(grant), 32'h1);
        req       = 4'b0000;
        mem_ready = 1'b1;
        step("single_done");
        chk("single_done_lit", 32'(done), 32'h1);
        chk("single_idle_valid", 32'(mem_valid), 32'h0);
        mem_ready = 1'b0;

        // Serve requester 1, then 0011 must go to requester 0.
        req = 4'b0010;
        step("rr_g1");
        req       = 4'b0000;
        mem_ready = 1'b1;
        step("rr_d1");
        mem_ready = 1'b0;
        req       = 4'b0011;
        step("rr_pick0");
        chk("rr_pick0_lit", 32'(grant), 32'h1);
        mem_ready = 1'b1;
        step("rr_handoff");
        chk("rr_handoff_lit", 32'(grant), 32'h2);
        req = 4'b0010;
        step("rr_last");
        chk("rr_last_idle", 32'(mem_valid), 32'h0);
        req       = 4'b0000;
        mem_ready = 1'b0;

        // Watchdog abort on owner 2; owner's req drop is ignored.
        req = 4'b0100;
        step("to_grant");
        req = 4'b0000;
        for (int i = 1; i <= 3; i++) step("to_wait");
        chk("to_wait_err", 32'(err), 32'h0);
        step("to_abort");
        chk("to_abort_err", 32'(err), 32'h4);
        chk("to_abort_done", 32'(done), 32'h0);
        chk("to_abort_valid", 32'(mem_valid), 32'h0);

        // Completion on the last watchdog cycle beats the abort.
        req = 4'b0100;
        step("tr_grant");
        req = 4'b0000;
        for (int i = 1; i <= 3; i++) step("tr_wait");
        mem_ready = 1'b1;
        step("tr_race");
        chk("tr_race_done", 32'(done), 32'h4);
        chk("tr_race_err", 32'(err), 32'h0);
        mem_ready = 1'b0;

        // Asynchronous reset while requester 3 owns the port.
        req = 4'b1000;
        step("ar_grant");
        chk("ar_grant_lit", 32'(grant), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_grant0", 32'(grant), 32'h0);
        chk("ar_valid0", 32'(mem_valid), 32'h0);
        chk("ar_done0", 32'(done), 32'h0);
        chk("ar_err0", 32'(err), 32'h0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("ar_idle");

        // All four requesting: back-to-back 0,1,2,3 with no bubble.
        req       = 4'b1111;
        mem_ready = 1'b1;
        step("b2b_g0");
        chk("b2b_g0_lit", 32'(grant), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            req[i-1] = 1'b0;
            step("b2b_handoff");
            chk("b2b_grant_lit", 32'(grant), 32'(1 << i));
            chk("b2b_done_lit", 32'(done), 32'(1 << (i - 1)));
            chk("b2b_valid_lit", 32'(mem_valid), 32'h1);
        end
        req[2] = 1'b0;
        step("b2b_end");
        req       = 4'b0000;
        mem_ready = 1'b0;

        // Random traffic; requesters obey the drop-on-done/err contract.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_done == i || m_err == i) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
            end
            mem_ready = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
